psram_arbiter: RTL and testbench

- Two-port arbiter sharing one PsramController command port (read/write/byte_write/addr/din/dout/busy) between two requesters, e.g. CPU port 0 and video/DMA port 1.
- Latches one request at a time and issues a single-cycle command pulse.
- Tracks controller busy to completion, then returns an ack pulse with read data to the granted requester.
- Sits between requesters and PsramController in the clk domain.

---
 rtl/psram_arb_pkg.sv | 20 ++
 rtl/psram_arb_pick.sv | 36 +++
 rtl/psram_arbiter.sv | 152 +++++++++++++++
 tb/tb_psram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_arb_pkg.sv
// Shared definitions for the two-port PSRAM arbiter.
//   state_t      : 2-bit arbiter FSM encoding (IDLE/CMD/SETTLE/WAIT)
//   PORT0/PORT1  : requester index constants
//   ADDR_W_DEF / DATA_W_DEF : default controller address/data widths
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    SETTLE = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/psram_arb_pick.sv
// Grant selector for the PSRAM arbiter.
// Ports:
//   clk, resetn      : clock, async active-low reset
//   req0, req1       : request levels
//   upd, upd_idx     : strobe + index of the port just completed (updates last_grant)
//   gnt_idx, gnt_vld : combinational choice for this cycle
// last_grant resets to PORT1 so port 0 wins the first contention.
module psram_arb_pick
  import psram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_idx,
  output logic gnt_idx,
  output logic gnt_vld
);

  logic last_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  last_grant <= PORT1;
    else if (upd) last_grant <= upd_idx;
  end

  always_comb begin
    gnt_vld = req0 | req1;
    if (req0 && req1) gnt_idx = (FIXED_PRIO != 0) ? PORT0 : ~last_grant;
    else              gnt_idx = req0 ? PORT0 : PORT1;
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a single PsramController command port.
// One request is latched at a time, issued as a one-cycle mem_read/mem_write
// pulse, tracked through controller busy, then acknowledged with read data.
// Ports:
//   clk, resetn                      : clock, async active-low reset
//   reqN/weN/bweN/addrN/wdataN       : requester N command (held until ackN)
//   ackN, rdataN                     : completion pulse and read word for port N
//   mem_read/mem_write/mem_byte_write/mem_addr/mem_din : controller command
//   mem_dout, mem_busy               : controller read data and busy
// Optional: define PSRAM_ARB_STATS_EN to add grant_cnt0/grant_cnt1/wait_cnt
// saturating statistics counters.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0,
  parameter int STAT_W     = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              bwe0,
  input  logic              bwe1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_busy
`ifdef PSRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
  output logic [STAT_W-1:0] wait_cnt
`endif
);

  state_t state, nstate;
  logic   sel;      // port owning the in-flight transaction
  logic   we_q;
  logic   gnt_idx, gnt_vld;
  logic   take, done;

  // IDLE only grants once the controller is free; this also covers init
  // and a controller still busy after a mid-transaction reset.
  assign take = (state == IDLE) && !mem_busy && gnt_vld;
  assign done = (state == WAIT) && !mem_busy;

  psram_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .clk     (clk),
    .resetn  (resetn),
    .req0    (req0),
    .req1    (req1),
    .upd     (done),
    .upd_idx (sel),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nstate;
  end

  // Next state; SETTLE exists because busy may lag the command by a cycle.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (take) nstate = CMD;
      CMD:     nstate = SETTLE;
      SETTLE:  nstate = WAIT;
      WAIT:    if (!mem_busy) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Command pulses exist only in CMD; the rest of the command is held in regs.
  always_comb begin
    mem_read  = (state == CMD) && !we_q;
    mem_write = (state == CMD) &&  we_q;
  end

  // Datapath: latch on grant, capture read data and pulse ack on completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel            <= PORT0;
      we_q           <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (take) begin
        sel <= gnt_idx;
        if (gnt_idx == PORT0) begin
          we_q <= we0; mem_byte_write <= bwe0; mem_addr <= addr0; mem_din <= wdata0;
        end else begin
          we_q <= we1; mem_byte_write <= bwe1; mem_addr <= addr1; mem_din <= wdata1;
        end
      end
      if (done) begin
        if (sel == PORT0) begin
          ack0 <= 1'b1;
          if (!we_q) rdata0 <= mem_dout;
        end else begin
          ack1 <= 1'b1;
          if (!we_q) rdata1 <= mem_dout;
        end
      end
    end
  end

`ifdef PSRAM_ARB_STATS_EN
  logic active, wait0, wait1;
  assign active = (state != IDLE);
  // A port is waiting when it requests but does not own the in-flight slot.
  assign wait0  = req0 && !(active && sel == PORT0);
  assign wait1  = req1 && !(active && sel == PORT1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      wait_cnt   <= '0;
    end else begin
      if (ack0 && !(&grant_cnt0))         grant_cnt0 <= grant_cnt0 + 1'b1;
      if (ack1 && !(&grant_cnt1))         grant_cnt1 <= grant_cnt1 + 1'b1;
      if ((wait0 || wait1) && !(&wait_cnt)) wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: a round-robin instance (a_*) and a
// fixed-priority STAT_W=4 instance (b_*) share requester stimulus; each has
// its own simple controller model that holds busy for busy_len cycles after
// a command.
module tb_psram_arbiter;
  localparam int AW = 22;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, bwe0 = 0, bwe1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, model_dout = '0;
  logic          init_busy = 1'b1;
  int            busy_len = 0;

  logic          a_ack0, a_ack1, a_rd_p, a_wr_p, a_bw, a_busy;
  logic [DW-1:0] a_rdata0, a_rdata1, a_din;
  logic [AW-1:0] a_addr;
  logic          b_ack0, b_ack1, b_rd_p, b_wr_p, b_bw, b_busy;
  logic [DW-1:0] b_rdata0, b_rdata1, b_din;
  logic [AW-1:0] b_addr;
`ifdef PSRAM_ARB_STATS_EN
  logic [23:0] a_gc0, a_gc1, a_wc;
  logic [3:0]  b_gc0, b_gc1, b_wc;
`endif

  int a_cnt = 0, b_cnt = 0;
  always @(posedge clk) begin
    if (a_rd_p || a_wr_p) a_cnt <= busy_len; else if (a_cnt > 0) a_cnt <= a_cnt - 1;
    if (b_rd_p || b_wr_p) b_cnt <= busy_len; else if (b_cnt > 0) b_cnt <= b_cnt - 1;
  end
  assign a_busy = init_busy | (a_cnt != 0);
  assign b_busy = init_busy | (b_cnt != 0);

  psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .STAT_W(24)) dut_a (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .bwe0(bwe0), .bwe1(bwe1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1),
    .mem_read(a_rd_p), .mem_write(a_wr_p), .mem_byte_write(a_bw), .mem_addr(a_addr),
    .mem_din(a_din), .mem_dout(model_dout), .mem_busy(a_busy)
`ifdef PSRAM_ARB_STATS_EN
    , .grant_cnt0(a_gc0), .grant_cnt1(a_gc1), .wait_cnt(a_wc)
`endif
  );

  psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .STAT_W(4)) dut_b (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .bwe0(bwe0), .bwe1(bwe1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_read(b_rd_p), .mem_write(b_wr_p), .mem_byte_write(b_bw), .mem_addr(b_addr),
    .mem_din(b_din), .mem_dout(model_dout), .mem_busy(b_busy)
`ifdef PSRAM_ARB_STATS_EN
    , .grant_cnt0(b_gc0), .grant_cnt1(b_gc1), .wait_cnt(b_wc)
`endif
  );

  int checks = 0, errors = 0;
  int cyc = 0, a_rd = 0, a_wr = 0, a_k0 = 0, a_k1 = 0, b_k0 = 0, b_k1 = 0;
  int pulse_cyc = -1, fall_cyc = -1, ack_cyc = -1;
  logic          prev_busy = 1'b1;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_din;
  logic          cap_bw;
  bit            auto_drop = 1;
  int            seq_a[$], seq_b[$];

  // Advance one cycle and sample 1ns after the edge.
  task automatic tick();
    @(posedge clk); #1; cyc++;
    if (prev_busy && !a_busy) fall_cyc = cyc;
    prev_busy = a_busy;
    if (a_rd_p || a_wr_p) begin
      pulse_cyc = cyc; cap_addr = a_addr; cap_din = a_din; cap_bw = a_bw;
      if (a_rd_p) a_rd++; else a_wr++;
    end
    if (a_ack0) begin a_k0++; ack_cyc = cyc; seq_a.push_back(0); if (auto_drop) req0 = 0; end
    if (a_ack1) begin a_k1++; ack_cyc = cyc; seq_a.push_back(1); if (auto_drop) req1 = 0; end
    if (b_ack0) begin b_k0++; seq_b.push_back(0); end
    if (b_ack1) begin b_k1++; seq_b.push_back(1); end
  endtask

  task automatic clear();
    a_rd = 0; a_wr = 0; a_k0 = 0; a_k1 = 0; b_k0 = 0; b_k1 = 0;
    seq_a.delete(); seq_b.delete();
  endtask

  task automatic wait_acks(input int n, input string tag);
    int t = 0;
    while ((a_k0 + a_k1) < n && t < 400) begin tick(); t++; end
    checks++;
    if ((a_k0 + a_k1) < n) begin
      errors++; $display("FAIL %s ack timeout: got %0d acks, want %0d", tag, a_k0 + a_k1, n);
    end
  endtask

  task automatic test_reset();
    resetn = 0; init_busy = 1;
    tick(); tick();
    checks++;
    if ({a_ack0, a_ack1, a_rd_p, a_wr_p, a_bw, a_addr, a_din, a_rdata0, a_rdata1,
         b_ack0, b_ack1, b_rd_p, b_wr_p, b_bw, b_addr, b_din, b_rdata0, b_rdata1} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero, a_addr=%h a_rdata0=%h", a_addr, a_rdata0);
    end
`ifdef PSRAM_ARB_STATS_EN
    checks++;
    if ({a_gc0, a_gc1, a_wc, b_gc0, b_gc1, b_wc} !== '0) begin
      errors++; $display("FAIL reset_stats: a_gc0=%0d a_gc1=%0d a_wc=%0d, want 0", a_gc0, a_gc1, a_wc);
    end
`endif
    resetn = 1;
  endtask

  task automatic test_init();
    int f;
    clear(); model_dout = 16'h0042; addr0 = 22'h10; we0 = 0; req0 = 1;
    repeat (50) tick();
    checks++;
    if (a_rd + a_wr != 0) begin
      errors++; $display("FAIL init_no_cmd: %0d pulses during busy, want 0", a_rd + a_wr);
    end
    init_busy = 0; f = cyc;
    wait_acks(1, "init");
    checks++;
    if (pulse_cyc != f + 1) begin
      errors++; $display("FAIL init_cmd_time: pulse at %0d, want %0d", pulse_cyc, f + 1);
    end
    repeat (3) tick();
    checks++;
    if (a_rd != 1 || a_wr != 0) begin
      errors++; $display("FAIL init_one_pulse: rd=%0d wr=%0d, want 1/0", a_rd, a_wr);
    end
  endtask

  task automatic test_latency();
    int s;
    clear(); busy_len = 0; model_dout = 16'h7E81; addr0 = 22'h20; req0 = 1; s = cyc;
    wait_acks(1, "latency");
    checks++;
    if (pulse_cyc != s + 1 || ack_cyc != s + 4) begin
      errors++; $display("FAIL latency: cmd %0d ack %0d, want %0d %0d", pulse_cyc, ack_cyc, s + 1, s + 4);
    end
  endtask

  task automatic test_single_read();
    clear(); busy_len = 8; model_dout = 16'hA5C3; addr0 = 22'h001234; we0 = 0; req0 = 1;
    wait_acks(1, "read");
    repeat (3) tick();
    checks++;
    if (a_rd != 1 || a_wr != 0) begin
      errors++; $display("FAIL read_pulses: rd=%0d wr=%0d, want 1/0", a_rd, a_wr);
    end
    checks++;
    if (cap_addr !== 22'h001234) begin
      errors++; $display("FAIL read_addr: got %h want 001234", cap_addr);
    end
    checks++;
    if (ack_cyc != fall_cyc + 1) begin
      errors++; $display("FAIL read_ack_time: ack %0d busy_fall %0d, want fall+1", ack_cyc, fall_cyc);
    end
    checks++;
    if (a_rdata0 !== 16'hA5C3) begin
      errors++; $display("FAIL read_rdata0: got %h want a5c3", a_rdata0);
    end
    checks++;
    if (a_k1 != 0 || a_k0 != 1) begin
      errors++; $display("FAIL read_acks: ack0=%0d ack1=%0d, want 1/0", a_k0, a_k1);
    end
  endtask

  task automatic test_byte_write();
    clear(); busy_len = 2; model_dout = 16'h0F0F; addr1 = 22'h2; we1 = 0; req1 = 1;
    wait_acks(1, "p1_read");
    checks++;
    if (a_rdata1 !== 16'h0F0F || a_k0 != 0) begin
      errors++; $display("FAIL p1_read: rdata1=%h ack0=%0d, want 0f0f/0", a_rdata1, a_k0);
    end
    clear(); busy_len = 4; model_dout = 16'hFFFF;
    we1 = 1; bwe1 = 1; addr1 = 22'h3FFFFF; wdata1 = 16'h5A5A; req1 = 1;
    wait_acks(1, "bwrite");
    checks++;
    if (a_wr != 1 || a_rd != 0) begin
      errors++; $display("FAIL bw_pulses: wr=%0d rd=%0d, want 1/0", a_wr, a_rd);
    end
    checks++;
    if (cap_bw !== 1'b1 || cap_din !== 16'h5A5A || cap_addr !== 22'h3FFFFF) begin
      errors++; $display("FAIL bw_cmd: bw=%b din=%h addr=%h, want 1/5a5a/3fffff", cap_bw, cap_din, cap_addr);
    end
    checks++;
    if (a_rdata1 !== 16'h0F0F || a_k1 != 1) begin
      errors++; $display("FAIL bw_rdata1: rdata1=%h ack1=%0d, want 0f0f/1", a_rdata1, a_k1);
    end
    addr1 = '0; wdata1 = '0; we1 = 0; bwe1 = 0;
    repeat (3) tick();
    checks++;
    if (a_addr !== 22'h3FFFFF || a_din !== 16'h5A5A || a_bw !== 1'b1 || a_rd_p || a_wr_p) begin
      errors++; $display("FAIL hold_cmd: addr=%h din=%h bw=%b, want 3fffff/5a5a/1 idle", a_addr, a_din, a_bw);
    end
  endtask

  task automatic test_reset_midop();
    int t = 0;
    clear(); busy_len = 20; model_dout = 16'h1357; addr0 = 22'h55; we0 = 0; req0 = 1;
    while (a_rd == 0 && t < 100) begin tick(); t++; end
    repeat (5) tick();
    resetn = 0; #1;
    checks++;
    if ({a_ack0, a_ack1, a_rd_p, a_wr_p, a_bw, a_addr, a_din, a_rdata0, a_rdata1} !== '0) begin
      errors++; $display("FAIL midop_reset: addr=%h rdata0=%h rdata1=%h, want 0", a_addr, a_rdata0, a_rdata1);
    end
    tick(); tick(); resetn = 1;
    a_rd = 0; t = 0;
    while (a_rd == 0 && t < 100) begin tick(); t++; end
    checks++;
    if (a_rd == 0 || pulse_cyc != fall_cyc + 1) begin
      errors++; $display("FAIL midop_regrant: cmd %0d busy_fall %0d, want fall+1", pulse_cyc, fall_cyc);
    end
    wait_acks(1, "midop_done");
  endtask

  task automatic test_contention();
    int t = 0;
    logic [5:0] got_a, got_b;
    resetn = 0; tick(); resetn = 1;
    clear(); auto_drop = 0; busy_len = 3; we0 = 0; we1 = 0; addr0 = 22'h1; addr1 = 22'h2;
    req0 = 1; req1 = 1;
    while (seq_a.size() < 6 && t < 500) begin tick(); t++; end
    req0 = 0; req1 = 0;
    repeat (10) tick();
    auto_drop = 1;
    got_a = '1; got_b = '1;
    for (int i = 0; i < 6 && i < seq_a.size(); i++) got_a[i] = seq_a[i][0];
    for (int i = 0; i < 6 && i < seq_b.size(); i++) got_b[i] = seq_b[i][0];
    checks++;
    if (seq_a.size() != 6 || got_a !== 6'b101010) begin
      errors++; $display("FAIL rr_order: n=%0d order(lsb first)=%b, want 6/101010", seq_a.size(), got_a);
    end
    checks++;
    if (seq_b.size() != 6 || got_b !== 6'b000000 || b_k1 != 0) begin
      errors++; $display("FAIL fixed_order: n=%0d order=%b ack1=%0d, want 6/000000/0", seq_b.size(), got_b, b_k1);
    end
`ifdef PSRAM_ARB_STATS_EN
    checks++;
    if (a_gc0 !== 24'd3 || a_gc1 !== 24'd3 || a_wc == 0) begin
      errors++; $display("FAIL rr_stats: gc0=%0d gc1=%0d wc=%0d, want 3/3/>0", a_gc0, a_gc1, a_wc);
    end
`endif
  endtask

`ifdef PSRAM_ARB_STATS_EN
  task automatic test_stats_sat();
    clear(); busy_len = 0; we0 = 0; addr0 = 22'h30;
    for (int i = 1; i <= 21; i++) begin
      req0 = 1; wait_acks(i, "sat");
    end
    repeat (3) tick();
    checks++;
    if (b_gc0 !== 4'hF || b_gc1 !== 4'h0) begin
      errors++; $display("FAIL stat_sat: b_gc0=%h b_gc1=%h, want f/0", b_gc0, b_gc1);
    end
    checks++;
    if (a_gc0 !== 24'd24) begin
      errors++; $display("FAIL stat_count: a_gc0=%0d, want 24", a_gc0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_latency();
    test_single_read();
    test_byte_write();
    test_reset_midop();
    test_contention();
`ifdef PSRAM_ARB_STATS_EN
    test_stats_sat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
